wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage directly upstream of the 32x32 register file; it drives the file's write-enable, destination index and write data.
- ALU results are written one cycle after acceptance.
- Loads are accepted, held pending until the data memory returns read data, then byte/halfword-aligned and sign- or zero-extended before writeback.
- Single outstanding load; upstream is back-pressured while a load is pending.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- REG_AW, 5, register index width.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream presents an instruction result
- in_ready  output  1  stage can accept this cycle
- in_rd  input  REG_AW  destination register index
- in_is_load  input  1  1 = load, result comes from memory; 0 = ALU result
- in_funct3  input  3  load width/sign code (RV32I encoding)
- in_addr_lo  input  2  low two bits of the load effective address
- in_alu_result  input  XLEN  ALU result, used when in_is_load=0
- mem_rvalid  input  1  data memory read data valid
- mem_rdata  input  XLEN  raw aligned-word read data
- we  output  1  register file write enable, one-cycle pulse
- rd  output  REG_AW  register file destination index
- wdata  output  XLEN  register file write data
- busy  output  1  load pending (state WAIT)
- load_err  output  1  one-cycle pulse: unsupported load funct3 completed

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset. No other reset exists.
- Reset values: we=0, rd=0, wdata=0, busy=0, load_err=0, state=IDLE.
- in_ready is combinational: 1 in IDLE, 0 in WAIT. Transfer occurs when in_valid && in_ready at a rising edge.

State IDLE:
- Transfer with in_is_load=0:
  - Next cycle: we=(in_rd!=0), rd=in_rd, wdata=in_alu_result.
  - Latency 1 cycle, state stays IDLE.
  - Back-to-back ALU transfers give back-to-back we pulses.
- Transfer with in_is_load=1:
  - Capture in_rd, in_funct3, in_addr_lo.
  - Go to WAIT; we=0 next cycle.
- mem_rvalid is ignored in IDLE.
- No transfer: we=0 next cycle. rd and wdata hold their last value.

State WAIT:
- busy=1, in_ready=0.
- mem_rvalid is sampled no earlier than the cycle after load acceptance.
- On mem_rvalid, with sh = 8*addr_lo:
  - 000 LB: sign-extend byte (mem_rdata>>sh)[7:0]
  - 100 LBU: zero-extend the same byte
  - 001 LH: sign-extend halfword selected by addr_lo[1]; addr_lo[0] ignored
  - 101 LHU: zero-extend the same halfword
  - 010 LW: mem_rdata unchanged; addr_lo ignored
  - 011, 110, 111: we=0 and load_err=1 for one cycle; wdata unchanged
- After mem_rvalid:
  - Next cycle: we=(captured rd!=0), rd=captured rd, wdata=aligned value.
  - State returns to IDLE. Load completion latency is 1 cycle after mem_rvalid.
- No mem_rvalid: remain in WAIT indefinitely (no timeout).

General rules:
- A load completion cycle never coincides with an ALU writeback. A new transfer is accepted only in the cycle after the FSM re-enters IDLE.
- rd=0 is never written (we=0), for both ALU and load results. rd/wdata still update.
- reset asserted in WAIT: pending load dropped, state=IDLE, we=0 the following cycle. A mem_rvalid arriving after reset deasserts is ignored (IDLE).
- reset has priority over a simultaneous transfer or mem_rvalid.

Test Plan:
- ALU writeback: reset 2 cycles, then in_valid=1, is_load=0, rd=5, alu_result=0xDEADBEEF -> next cycle we=1, rd=5, wdata=0xDEADBEEF; following idle cycle we=0.
- x0 suppression: ALU transfer rd=0, result=0x12345678 -> we stays 0 every cycle, rd=0, wdata=0x12345678.
- Signed/unsigned bytes: mem_rdata=0x80FF7F01 for four loads with rd=3:
  - LB, addr_lo=3 -> wdata=0xFFFFFF80
  - LBU, addr_lo=3 -> 0x00000080
  - LB, addr_lo=1 -> 0x0000007F
  - LH, addr_lo=2 -> 0xFFFF80FF
- Stall/handshake: load rd=7, mem_rvalid withheld 4 cycles -> busy=1 and in_ready=0 for those cycles; an ALU in_valid held meanwhile is accepted only after the load writeback; load we then ALU we on consecutive later cycles, in order.
- Reset mid-load: LW accepted, reset asserted in WAIT, then mem_rvalid=1 with rdata=0xAAAAAAAA -> no we pulse, busy=0, in_ready=1.
- Illegal funct3: load funct3=011, mem_rvalid -> we=0, load_err=1 for exactly one cycle, state returns to IDLE.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage feeding the register file: ALU results retire one cycle after
// acceptance, and a single outstanding load is aligned and extended when the data returns.
module wb_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_is_load,
  input  logic [2:0]        in_funct3,
  input  logic [1:0]        in_addr_lo,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              we,
  output logic [REG_AW-1:0] rd,
  output logic [XLEN-1:0]   wdata,
  output logic              busy,
  output logic              load_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              r_state;
  logic [REG_AW-1:0]   r_ld_rd;
  logic [2:0]          r_ld_f3;
  logic [1:0]          r_ld_lo;
  logic                r_we;
  logic [REG_AW-1:0]   r_rd;
  logic [XLEN-1:0]     r_wdata;
  logic                r_load_err;

  logic [XLEN-1:0]     w_shift;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [XLEN-1:0]     w_load_val;
  logic                w_load_ok;
  logic                w_xfer;

  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state == S_WAIT);
  assign w_xfer   = in_valid && in_ready;
  assign we       = r_we;
  assign rd       = r_rd;
  assign wdata    = r_wdata;
  assign load_err = r_load_err;

  // Halfword selection uses only addr_lo[1]; a misaligned halfword is not split.
  always_comb begin
    w_shift    = mem_rdata >> {r_ld_lo, 3'b000};
    w_byte     = w_shift[7:0];
    w_half     = r_ld_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_load_val = '0;
    w_load_ok  = 1'b1;
    case (r_ld_f3)
      3'b000:  w_load_val = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_load_val = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_load_val = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_load_val = {{(XLEN-16){1'b0}}, w_half};
      3'b010:  w_load_val = mem_rdata;
      default: w_load_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ld_rd    <= '0;
      r_ld_f3    <= '0;
      r_ld_lo    <= '0;
      r_we       <= 1'b0;
      r_rd       <= '0;
      r_wdata    <= '0;
      r_load_err <= 1'b0;
    end else begin
      r_we       <= 1'b0;
      r_load_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            if (in_is_load) begin
              r_ld_rd <= in_rd;
              r_ld_f3 <= in_funct3;
              r_ld_lo <= in_addr_lo;
              r_state <= S_WAIT;
            end else begin
              r_we    <= (in_rd != '0);
              r_rd    <= in_rd;
              r_wdata <= in_alu_result;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            r_state <= S_IDLE;
            if (w_load_ok) begin
              r_we    <= (r_ld_rd != '0);
              r_rd    <= r_ld_rd;
              r_wdata <= w_load_val;
            end else begin
              r_load_err <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU retire, x0 suppression, load alignment,
// stall handshake, reset during a pending load and illegal load widths.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_result;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] wdata;
  logic        busy;
  logic        load_err;

  int total = 0;
  int bad   = 0;

  wb_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_is_load(in_is_load), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .we(we), .rd(rd),
    .wdata(wdata), .busy(busy), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic alu_xfer(input logic [4:0] r, input logic [31:0] v);
    in_valid = 1'b1; in_is_load = 1'b0; in_rd = r; in_alu_result = v;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic load_xfer(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] r);
    in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = f3; in_addr_lo = lo; in_rd = r;
    tick;
    in_valid = 1'b0; in_is_load = 1'b0;
  endtask

  task automatic load_case(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                           input logic [4:0] r, input logic [31:0] data, input logic [31:0] exp);
    load_xfer(f3, lo, r);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_we_wait"}, {31'd0, we}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = data;
    tick;
    mem_rvalid = 1'b0;
    chk({tag, "_we"}, {31'd0, we}, {31'd0, (r != 5'd0)});
    chk({tag, "_rd"}, {27'd0, rd}, {27'd0, r});
    chk({tag, "_wdata"}, wdata, exp);
    chk({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    tick;
    chk({tag, "_we_off"}, {31'd0, we}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_is_load = 1'b0; in_funct3 = '0;
    in_addr_lo = '0; in_alu_result = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    tick; tick;
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_rd", {27'd0, rd}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_lerr", {31'd0, load_err}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;

    // ALU writeback, one-cycle pulse, outputs hold afterwards
    alu_xfer(5'd5, 32'hDEADBEEF);
    chk("alu_we", {31'd0, we}, 32'd1);
    chk("alu_rd", {27'd0, rd}, 32'd5);
    chk("alu_wdata", wdata, 32'hDEADBEEF);
    tick;
    chk("alu_we_off", {31'd0, we}, 32'd0);
    chk("alu_rd_hold", {27'd0, rd}, 32'd5);
    chk("alu_wdata_hold", wdata, 32'hDEADBEEF);

    // x0 is never written but rd/wdata still update
    alu_xfer(5'd0, 32'h12345678);
    chk("x0_we", {31'd0, we}, 32'd0);
    chk("x0_rd", {27'd0, rd}, 32'd0);
    chk("x0_wdata", wdata, 32'h12345678);
    tick;
    chk("x0_we_off", {31'd0, we}, 32'd0);

    // Back-to-back ALU transfers
    in_valid = 1'b1; in_is_load = 1'b0; in_rd = 5'd1; in_alu_result = 32'h1;
    tick;
    chk("b2b_we0", {31'd0, we}, 32'd1);
    in_rd = 5'd2; in_alu_result = 32'h2;
    tick;
    in_valid = 1'b0;
    chk("b2b_we1", {31'd0, we}, 32'd1);
    chk("b2b_rd1", {27'd0, rd}, 32'd2);
    tick;

    // mem_rvalid in IDLE does nothing
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick;
    mem_rvalid = 1'b0;
    chk("idle_rv_we", {31'd0, we}, 32'd0);
    chk("idle_rv_busy", {31'd0, busy}, 32'd0);
    chk("idle_rv_wdata", wdata, 32'h2);

    // Load alignment / extension
    load_case("lb3",  3'b000, 2'd3, 5'd3, 32'h80FF7F01, 32'hFFFFFF80);
    load_case("lbu3", 3'b100, 2'd3, 5'd3, 32'h80FF7F01, 32'h00000080);
    load_case("lb1",  3'b000, 2'd1, 5'd3, 32'h80FF7F01, 32'h0000007F);
    load_case("lh2",  3'b001, 2'd2, 5'd3, 32'h80FF7F01, 32'hFFFF80FF);
    load_case("lhu3", 3'b101, 2'd3, 5'd3, 32'h80FF7F01, 32'h000080FF);
    load_case("lh0",  3'b001, 2'd0, 5'd3, 32'h80FF7F01, 32'h00007F01);
    load_case("lb0",  3'b000, 2'd0, 5'd3, 32'h80FF7F01, 32'h00000001);
    load_case("lw1",  3'b010, 2'd1, 5'd3, 32'h80FF7F01, 32'h80FF7F01);
    load_case("ldx0", 3'b010, 2'd0, 5'd0, 32'h13572468, 32'h13572468);

    // Stall: load pending for 4 cycles while an ALU op waits upstream
    load_xfer(3'b010, 2'd0, 5'd7);
    in_valid = 1'b1; in_is_load = 1'b0; in_rd = 5'd9; in_alu_result = 32'h00000011;
    for (int i = 0; i < 4; i++) begin
      chk("stall_busy", {31'd0, busy}, 32'd1);
      chk("stall_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_we", {31'd0, we}, 32'd0);
      tick;
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick;
    mem_rvalid = 1'b0;
    chk("stall_ld_we", {31'd0, we}, 32'd1);
    chk("stall_ld_rd", {27'd0, rd}, 32'd7);
    chk("stall_ld_wdata", wdata, 32'hCAFEF00D);
    tick;
    in_valid = 1'b0;
    chk("stall_alu_we", {31'd0, we}, 32'd1);
    chk("stall_alu_rd", {27'd0, rd}, 32'd9);
    chk("stall_alu_wdata", wdata, 32'h00000011);
    tick;
    chk("stall_we_off", {31'd0, we}, 32'd0);

    // Reset while a load is pending drops it
    load_xfer(3'b010, 2'd0, 5'd4);
    chk("rstw_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rstw_busy0", {31'd0, busy}, 32'd0);
    chk("rstw_ready", {31'd0, in_ready}, 32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'hAAAAAAAA;
    tick;
    mem_rvalid = 1'b0;
    chk("rstw_we", {31'd0, we}, 32'd0);
    chk("rstw_busy1", {31'd0, busy}, 32'd0);
    chk("rstw_wdata", wdata, 32'd0);

    // Reset beats a simultaneous transfer
    reset = 1'b1; in_valid = 1'b1; in_is_load = 1'b0; in_rd = 5'd6; in_alu_result = 32'h66;
    tick;
    reset = 1'b0; in_valid = 1'b0;
    chk("rstp_we", {31'd0, we}, 32'd0);
    chk("rstp_rd", {27'd0, rd}, 32'd0);
    chk("rstp_wdata", wdata, 32'd0);

    // Unsupported load widths
    alu_xfer(5'd8, 32'h00000055);
    tick;
    for (int k = 0; k < 3; k++) begin
      logic [2:0] f3;
      f3 = (k == 0) ? 3'b011 : (k == 1) ? 3'b110 : 3'b111;
      load_xfer(f3, 2'd0, 5'd3);
      mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
      tick;
      mem_rvalid = 1'b0;
      chk("ill_we", {31'd0, we}, 32'd0);
      chk("ill_lerr", {31'd0, load_err}, 32'd1);
      chk("ill_wdata", wdata, 32'h00000055);
      chk("ill_idle", {31'd0, in_ready}, 32'd1);
      tick;
      chk("ill_lerr_off", {31'd0, load_err}, 32'd0);
      chk("ill_we_off", {31'd0, we}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
